// File: rtl/cic_pkg.sv
// Shared CIC definitions: default widths and the index-width helpers used by
// the integrator, comb and decimator blocks.
package cic_pkg;

  localparam int DEF_IN_BITS  = 10;
  localparam int DEF_ACC_BITS = 32;
  localparam int DEF_STAGES   = 3;
  localparam int DEF_CHANNELS = 2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // A single channel still needs a one-bit index port.
  function automatic int ch_width(input int channels);
    return (clog2(channels) < 1) ? 1 : clog2(channels);
  endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// One integrator stage: a per-channel accumulator bank plus the pipeline
// register that carries the updated sum to the next stage.
module cic_integrator_stage
  import cic_pkg::*;
#(
  parameter int ACC_BITS = DEF_ACC_BITS,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int CH_W     = ch_width(DEF_CHANNELS)
) (
  input  logic                clk,
  input  logic                flush,
  input  logic [ACC_BITS-1:0] x_data,
  input  logic                x_valid,
  input  logic [CH_W-1:0]     x_chan,
  output logic [ACC_BITS-1:0] y_data,
  output logic                y_valid,
  output logic [CH_W-1:0]     y_chan
);

  logic [ACC_BITS-1:0] acc_q [CHANNELS];
  logic [ACC_BITS-1:0] acc_d [CHANNELS];
  logic [ACC_BITS-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic [CH_W-1:0]     chan_q, chan_d;
  logic [ACC_BITS-1:0] sum_s;

  // Accumulate into the addressed channel only; the sum wraps modulo 2^ACC_BITS.
  always_comb begin
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = 1'b0;
    chan_d  = chan_q;
    sum_s   = {ACC_BITS{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      if (x_valid && (x_chan == CH_W'(c))) begin
        sum_s    = acc_q[c] + x_data;
        acc_d[c] = sum_s;
        data_d   = sum_s;
        valid_d  = 1'b1;
        chan_d   = x_chan;
      end else begin
        acc_d[c] = acc_q[c];
      end
    end
  end

  // State update; flush empties the accumulators and the pipeline register.
  always_ff @(posedge clk) begin
    if (flush) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c] <= {ACC_BITS{1'b0}};
      end
      data_q  <= {ACC_BITS{1'b0}};
      valid_q <= 1'b0;
      chan_q  <= {CH_W{1'b0}};
    end else begin
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      chan_q  <= chan_d;
    end
  end

  assign y_data  = data_q;
  assign y_valid = valid_q;
  assign y_chan  = chan_q;

endmodule

// File: rtl/cic_integrator_bank.sv
// Multichannel CIC integrator section: STAGES cascaded integrator stages over
// time-multiplexed channels, one sample per cycle, latency STAGES cycles.
module cic_integrator_bank
  import cic_pkg::*;
#(
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int ACC_BITS = DEF_ACC_BITS,
  parameter int STAGES   = DEF_STAGES,
  parameter int CHANNELS = DEF_CHANNELS,
  localparam int CH_W    = ch_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_BITS-1:0]  in_data,
  input  logic                in_valid,
  input  logic [CH_W-1:0]     in_chan,
  input  logic                clear,
  output logic [ACC_BITS-1:0] out_data,
  output logic                out_valid,
  output logic [CH_W-1:0]     out_chan
);

  logic [STAGES:0][ACC_BITS-1:0] data_s;
  logic [STAGES:0]               valid_s;
  logic [STAGES:0][CH_W-1:0]     chan_s;
  logic                          flush_s;
  logic                          chan_ok_s;

  assign flush_s   = rst | clear;
  // Indices beyond the channel count are dropped before touching any state.
  assign chan_ok_s = ({1'b0, in_chan} < (CH_W+1)'(CHANNELS));

  assign data_s[0]  = ACC_BITS'($signed(in_data));
  assign valid_s[0] = in_valid & chan_ok_s;
  assign chan_s[0]  = in_chan;

  generate
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
      cic_integrator_stage #(
        .ACC_BITS (ACC_BITS),
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W)
      ) u_stage (
        .clk     (clk),
        .flush   (flush_s),
        .x_data  (data_s[s]),
        .x_valid (valid_s[s]),
        .x_chan  (chan_s[s]),
        .y_data  (data_s[s+1]),
        .y_valid (valid_s[s+1]),
        .y_chan  (chan_s[s+1])
      );
    end
  endgenerate

  assign out_data  = data_s[STAGES];
  assign out_valid = valid_s[STAGES];
  assign out_chan  = chan_s[STAGES];

endmodule

// File: tb/tb_cic_integrator_bank.sv
// Directed bench for cic_integrator_bank: two-channel main instance plus a
// three-channel instance used for the out-of-range channel case.
module tb_cic_integrator_bank;

  localparam int IW = 10;
  localparam int AW = 16;
  localparam int NV = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, clear, in_valid;
  logic [IW-1:0] in_data;
  logic          in_chan;
  logic [1:0]    in_chan2;
  logic [AW-1:0] out_data, out_data2;
  logic          out_valid, out_valid2;
  logic          out_chan;
  logic [1:0]    out_chan2;

  cic_integrator_bank #(.IN_BITS(IW), .ACC_BITS(AW), .STAGES(3), .CHANNELS(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_chan(in_chan),
    .clear(clear), .out_data(out_data), .out_valid(out_valid), .out_chan(out_chan)
  );

  cic_integrator_bank #(.IN_BITS(IW), .ACC_BITS(AW), .STAGES(3), .CHANNELS(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_chan(in_chan2),
    .clear(clear), .out_data(out_data2), .out_valid(out_valid2), .out_chan(out_chan2)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic          vv [NV], vclr [NV], vrst [NV], ev [NV];
  logic [1:0]    vc [NV], ec [NV];
  logic [IW-1:0] vd [NV];
  logic [AW-1:0] ed [NV];
  logic [AW-1:0] hold_d;
  logic [1:0]    hold_c;
  logic [AW-1:0] a0, a1, a2;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_vecs();
    for (int i = 0; i < NV; i++) begin
      vv[i] = 1'b0; vclr[i] = 1'b0; vrst[i] = 1'b0; ev[i] = 1'b0;
      vc[i] = 2'd0; ec[i] = 2'd0; vd[i] = '0; ed[i] = '0;
    end
  endtask

  task automatic put_in(input int idx, input logic [1:0] c, input logic [IW-1:0] d);
    vv[idx] = 1'b1; vc[idx] = c; vd[idx] = d;
  endtask

  task automatic expect_out(input int idx, input logic [1:0] c, input logic [AW-1:0] d);
    ev[idx] = 1'b1; ec[idx] = c; ed[idx] = d;
  endtask

  // Idle slots expect the held output; a flush at slot i shows zero at slot i.
  task automatic finalize(input int n);
    for (int i = 0; i < n; i++) begin
      if (vrst[i] || vclr[i]) begin
        hold_d = '0; hold_c = 2'd0;
      end
      if (ev[i]) begin
        hold_d = ed[i]; hold_c = ec[i];
      end else begin
        ed[i] = hold_d; ec[i] = hold_c;
      end
    end
  endtask

  task automatic run_vec(input int n, input bit sel, input string tag);
    logic          ov;
    logic [AW-1:0] od;
    logic [1:0]    oc;
    finalize(n);
    for (int i = 0; i < n; i++) begin
      rst = vrst[i]; clear = vclr[i]; in_valid = vv[i];
      in_chan2 = vc[i]; in_chan = vc[i][0]; in_data = vd[i];
      @(posedge clk);
      #1;
      if (sel) begin
        ov = out_valid2; od = out_data2; oc = out_chan2;
      end else begin
        ov = out_valid; od = out_data; oc = {1'b0, out_chan};
      end
      check_eq($sformatf("%s[%0d].valid", tag, i), 32'(ov), 32'(ev[i]));
      check_eq($sformatf("%s[%0d].data", tag, i), 32'(od), 32'(ed[i]));
      check_eq($sformatf("%s[%0d].chan", tag, i), 32'(oc), 32'(ec[i]));
    end
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
  endtask

  task automatic do_clear(input string tag);
    clear_vecs();
    vclr[0] = 1'b1;
    run_vec(1, 1'b0, tag);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_chan = 1'b0; in_chan2 = 2'd0;
    hold_d = '0; hold_c = 2'd0;

    // Reset for two cycles, then quiet: outputs all zero.
    clear_vecs();
    vrst[0] = 1'b1; vrst[1] = 1'b1;
    run_vec(4, 1'b0, "reset");

    // Impulse on ch0: 1,3,6,10,15 starting three cycles after the impulse.
    clear_vecs();
    put_in(0, 2'd0, 10'd1);
    for (int i = 1; i < 5; i++) put_in(i, 2'd0, 10'd0);
    expect_out(2, 2'd0, 16'd1);  expect_out(3, 2'd0, 16'd3); expect_out(4, 2'd0, 16'd6);
    expect_out(5, 2'd0, 16'd10); expect_out(6, 2'd0, 16'd15);
    run_vec(9, 1'b0, "impulse");

    // Negative unit sample.
    do_clear("clr1");
    clear_vecs();
    put_in(0, 2'd0, 10'h3FF); put_in(1, 2'd0, 10'd0); put_in(2, 2'd0, 10'd0);
    expect_out(2, 2'd0, 16'hFFFF); expect_out(3, 2'd0, 16'hFFFD); expect_out(4, 2'd0, 16'hFFFA);
    run_vec(6, 1'b0, "negative");

    // Interleaved channels.
    do_clear("clr2");
    clear_vecs();
    put_in(0, 2'd0, 10'd1); put_in(1, 2'd1, 10'd2);
    put_in(2, 2'd0, 10'd0); put_in(3, 2'd1, 10'd0);
    put_in(4, 2'd0, 10'd0); put_in(5, 2'd1, 10'd0);
    expect_out(2, 2'd0, 16'd1); expect_out(3, 2'd1, 16'd2);
    expect_out(4, 2'd0, 16'd3); expect_out(5, 2'd1, 16'd6);
    expect_out(6, 2'd0, 16'd6); expect_out(7, 2'd1, 16'd12);
    run_vec(9, 1'b0, "interleave");

    // Clear with a sample in flight and a simultaneous sample: both lost.
    clear_vecs();
    put_in(0, 2'd0, 10'd7);
    put_in(1, 2'd0, 10'd5); vclr[1] = 1'b1;
    put_in(4, 2'd0, 10'd1); put_in(5, 2'd0, 10'd0); put_in(6, 2'd0, 10'd0);
    expect_out(6, 2'd0, 16'd1); expect_out(7, 2'd0, 16'd3); expect_out(8, 2'd0, 16'd6);
    run_vec(10, 1'b0, "clear_in_valid");

    // Reset mid-stream: earlier samples never emerge.
    clear_vecs();
    put_in(0, 2'd1, 10'd3); put_in(1, 2'd0, 10'd3);
    put_in(2, 2'd1, 10'd3); vrst[2] = 1'b1;
    put_in(4, 2'd1, 10'd1); put_in(5, 2'd1, 10'd0); put_in(6, 2'd1, 10'd0);
    expect_out(6, 2'd1, 16'd1); expect_out(7, 2'd1, 16'd3); expect_out(8, 2'd1, 16'd6);
    run_vec(10, 1'b0, "midreset");

    // Full-scale positive constant: wraps modulo 2^16.
    do_clear("clr3");
    clear_vecs();
    a0 = '0; a1 = '0; a2 = '0;
    for (int i = 0; i < 40; i++) begin
      put_in(i, 2'd0, 10'd511);
      a0 = a0 + 16'd511; a1 = a1 + a0; a2 = a2 + a1;
      expect_out(i + 2, 2'd0, a2);
    end
    run_vec(43, 1'b0, "wrap");

    // Three-channel instance: channel index 3 is out of range and ignored.
    clear_vecs();
    vrst[0] = 1'b1;
    run_vec(2, 1'b1, "reset3");
    clear_vecs();
    put_in(0, 2'd3, 10'd100);
    put_in(1, 2'd0, 10'd1); put_in(2, 2'd0, 10'd0); put_in(3, 2'd0, 10'd0);
    put_in(4, 2'd3, 10'd50);
    put_in(5, 2'd2, 10'd4);
    expect_out(3, 2'd0, 16'd1); expect_out(4, 2'd0, 16'd3); expect_out(5, 2'd0, 16'd6);
    expect_out(7, 2'd2, 16'd4);
    run_vec(10, 1'b1, "badchan");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cic_integrator_bank.md
CIC_INTEGRATOR_BANK -- requirements
Module: cic_integrator_bank

Interface
REQ-001 The block SHALL have parameter IN_BITS, default 10, meaning input sample width (two's complement).
REQ-002 The block SHALL have parameter ACC_BITS, default 32, meaning accumulator and output width, ACC_BITS >= IN_BITS.
REQ-003 The block SHALL have parameter STAGES, default 3, meaning the number of cascaded integrator stages, 1..8.
REQ-004 The block SHALL have parameter CHANNELS, default 2, meaning the number of time-multiplexed channels, 1..16; CH_W = max(1, clog2(CHANNELS)).
REQ-005 The block SHALL have port clk, input, 1 bit: the clock.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 The block SHALL have port in_data, input, IN_BITS: the signed input sample.
REQ-008 The block SHALL have port in_valid, input, 1 bit: in_data/in_chan are valid this cycle.
REQ-009 The block SHALL have port in_chan, input, CH_W: the channel index of the input sample.
REQ-010 The block SHALL have port clear, input, 1 bit: synchronous flush of all accumulators and the pipeline.
REQ-011 The block SHALL have port out_data, output, ACC_BITS: the output of the last integrator stage.
REQ-012 The block SHALL have port out_valid, output, 1 bit: out_data/out_chan are valid this cycle.
REQ-013 The block SHALL have port out_chan, output, CH_W: the channel of out_data.

Function
REQ-014 Each stage s SHALL hold CHANNELS independent accumulators acc[s][c] of ACC_BITS, plus one pipeline register (data, valid, chan).
REQ-015 Stage 0 input SHALL be in_data sign-extended to ACC_BITS; stage s>0 input SHALL be the pipeline register of stage s-1.
REQ-016 On a valid stage input for channel c: acc[s][c] <= acc[s][c] + x; the stage pipeline register SHALL load that updated sum, valid=1, chan=c.
REQ-017 On a non-valid stage input, the accumulators SHALL hold and the stage pipeline valid SHALL be 0 next cycle.
REQ-018 Latency SHALL be exactly STAGES cycles from in_valid to out_valid; throughput SHALL be one sample per cycle, with no backpressure.
REQ-019 Back-to-back samples on the same channel SHALL be correct, with no stall and no hazard; each stage reads and writes only its own accumulators.
REQ-020 Arithmetic SHALL be modulo 2^ACC_BITS, wrapping with no saturation and no overflow flag, as required for CIC correctness.
REQ-021 in_valid with in_chan >= CHANNELS SHALL be discarded, modifying no state and producing no output.
REQ-022 Channels SHALL be isolated: a sample on channel c SHALL NOT alter any acc[*][c'] where c' != c.
REQ-023 clear SHALL zero every accumulator and every pipeline valid/data/chan on the next edge; samples in flight SHALL be lost.
REQ-024 When clear and in_valid are asserted together, clear SHALL win and the sample SHALL be dropped.
REQ-025 out_data/out_chan SHALL hold their last value while out_valid=0.

Reset
REQ-026 rst SHALL have priority over clear and in_valid, with the same effect as clear.
REQ-027 After rst, the outputs SHALL be out_data=0, out_valid=0, out_chan=0, and all acc[s][c]=0.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight samples; the first out_valid after deassertion SHALL come only from a sample accepted after deassertion.

Structure
REQ-029 Package cic_pkg SHALL hold the default widths, the clog2 helper, and the channel-index width function shared with the comb/decimator blocks.
REQ-030 Sub-module cic_integrator_stage (one stage: CHANNELS accumulators plus pipeline register) SHALL be instantiated STAGES times via generate.
REQ-031 The accumulators SHALL be register arrays indexed by channel, with no RAM inference required.

Verification (IN_BITS=10, ACC_BITS=16, STAGES=3, CHANNELS=2)
REQ-032 Reset: rst high for 2 cycles -> out_valid=0, out_data=0, out_chan=0; no out_valid until the first input plus 3 cycles.
REQ-033 Impulse: ch0 in_data=1, then 4 zeros, back-to-back -> out on ch0 = 1,3,6,10,15, the first appearing 3 cycles after the impulse.
REQ-034 Negative: ch0 in_data=10'h3FF once, then 2 zeros -> out = 16'hFFFF, 16'hFFFD, 16'hFFFA.
REQ-035 Interleave: alternating ch0 (impulse 1, then zeros) and ch1 (impulse 2, then zeros) -> ch0 gives 1,3,6 and ch1 gives 2,6,12, with out_chan matching each sample.
REQ-036 Wrap and corner cases: ch0 constant 511 for 40 cycles -> output matches a modulo-2^16 golden model; an in_chan=3 sample is ignored; clear together with in_valid drops the sample and zeroes the state, and a following impulse of 1 restarts at 1,3,6.
